// File: rtl/cache_pkg.sv
// Shared cache definitions: refill FSM states, default geometry and block
// address helpers used by the controller, the ways and the refill engine.
package cache_pkg;

    localparam int CACHE_NUM_WAYS      = 4;
    localparam int CACHE_DATA_WIDTH    = 32;
    localparam int CACHE_BLOCK_SIZE    = 32;
    localparam int CACHE_ADDRESS_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_RD,
        WB_DATA,
        RD_REQ,
        RD_DATA
    } refill_state_e;

    function automatic int words_per_block(input int block_size, input int data_width);
        return (block_size * 8) / data_width;
    endfunction

    function automatic int offset_bits(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic logic [CACHE_ADDRESS_WIDTH-1:0] block_align(
        input logic [CACHE_ADDRESS_WIDTH-1:0] addr,
        input int                             obits
    );
        logic [CACHE_ADDRESS_WIDTH-1:0] mask;
        mask = '1;
        mask = mask << obits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/cache_refill_engine_if.sv
// Memory-side bus of the refill engine: command channel, writeback beats
// and fill beats. The engine is the master, backing memory the slave.
interface cache_refill_engine_if
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = CACHE_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = CACHE_DATA_WIDTH
);
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_write;
    logic [ADDRESS_WIDTH-1:0] mem_req_addr;
    logic                     mem_wdata_valid;
    logic                     mem_wdata_ready;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_rdata_valid;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     mem_rdata_last;

    modport master (
        output mem_req_valid, mem_req_write, mem_req_addr,
        output mem_wdata_valid, mem_wdata,
        input  mem_req_ready, mem_wdata_ready,
        input  mem_rdata_valid, mem_rdata, mem_rdata_last
    );

    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_addr,
        input  mem_wdata_valid, mem_wdata,
        output mem_req_ready, mem_wdata_ready,
        output mem_rdata_valid, mem_rdata, mem_rdata_last
    );

endinterface

// File: rtl/cache_refill_engine.sv
// Miss handler: optional dirty-victim writeback, then a burst fill of the
// missing block streamed word by word into the victim way.
module cache_refill_engine
    import cache_pkg::*;
#(
    parameter  int NUM_WAYS      = CACHE_NUM_WAYS,
    parameter  int DATA_WIDTH    = CACHE_DATA_WIDTH,
    parameter  int BLOCK_SIZE    = CACHE_BLOCK_SIZE,
    parameter  int ADDRESS_WIDTH = CACHE_ADDRESS_WIDTH,
    localparam int WAY_W         = $clog2(NUM_WAYS),
    localparam int WORDS         = words_per_block(BLOCK_SIZE, DATA_WIDTH),
    localparam int WORD_W        = $clog2(WORDS),
    localparam int OFFSET_BITS   = offset_bits(BLOCK_SIZE)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [ADDRESS_WIDTH-1:0] miss_addr,
    input  logic [WAY_W-1:0]         victim_way,
    input  logic                     victim_dirty,
    input  logic [ADDRESS_WIDTH-1:0] victim_addr,
    output logic                     wb_rd_en,
    output logic [WAY_W-1:0]         wb_rd_way,
    output logic [WORD_W-1:0]        wb_rd_word,
    input  logic [DATA_WIDTH-1:0]    wb_rd_data,
    output logic                     fill_we,
    output logic [WAY_W-1:0]         fill_way,
    output logic [WORD_W-1:0]        fill_word,
    output logic [DATA_WIDTH-1:0]    fill_data,
    output logic                     fill_done,
    output logic                     err,
    cache_refill_engine_if.master    mem
);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

    refill_state_e            state, next_state;
    logic [ADDRESS_WIDTH-1:0] miss_addr_q, victim_addr_q;
    logic [WAY_W-1:0]         way_q;
    logic [WORD_W-1:0]        count_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     rd_pending_q;
    logic                     fill_we_q, fill_done_q, err_q;
    logic [WAY_W-1:0]         fill_way_q;
    logic [WORD_W-1:0]        fill_word_q;
    logic [DATA_WIDTH-1:0]    fill_data_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // The way read data arrives in the first WB_DATA cycle, so it is forwarded
    // directly then and served from wdata_q while memory stalls the beat.
    always_comb begin
        next_state          = state;
        miss_ready          = 1'b0;
        mem.mem_req_valid   = 1'b0;
        mem.mem_req_write   = 1'b0;
        mem.mem_req_addr    = '0;
        mem.mem_wdata_valid = 1'b0;
        mem.mem_wdata       = '0;
        wb_rd_en            = 1'b0;
        wb_rd_way           = '0;
        wb_rd_word          = '0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) next_state = victim_dirty ? WB_REQ : RD_REQ;
            end
            WB_REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_write = 1'b1;
                mem.mem_req_addr  = ADDRESS_WIDTH'(block_align(
                                        CACHE_ADDRESS_WIDTH'(victim_addr_q), OFFSET_BITS));
                if (mem.mem_req_ready) next_state = WB_RD;
            end
            WB_RD: begin
                wb_rd_en   = 1'b1;
                wb_rd_way  = way_q;
                wb_rd_word = count_q;
                next_state = WB_DATA;
            end
            WB_DATA: begin
                mem.mem_wdata_valid = 1'b1;
                mem.mem_wdata       = rd_pending_q ? wb_rd_data : wdata_q;
                if (mem.mem_wdata_ready) next_state = (count_q == LAST_WORD) ? RD_REQ : WB_RD;
            end
            RD_REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_addr  = ADDRESS_WIDTH'(block_align(
                                        CACHE_ADDRESS_WIDTH'(miss_addr_q), OFFSET_BITS));
                if (mem.mem_req_ready) next_state = RD_DATA;
            end
            RD_DATA: begin
                if (fill_done_q || err_q) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // RD_DATA lingers one cycle after the closing beat so the done/err pulse
    // is visible before the engine accepts the next miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            way_q         <= '0;
            count_q       <= '0;
            wdata_q       <= '0;
            rd_pending_q  <= 1'b0;
            fill_we_q     <= 1'b0;
            fill_done_q   <= 1'b0;
            err_q         <= 1'b0;
            fill_way_q    <= '0;
            fill_word_q   <= '0;
            fill_data_q   <= '0;
        end else begin
            rd_pending_q <= 1'b0;
            fill_we_q    <= 1'b0;
            fill_done_q  <= 1'b0;
            err_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        miss_addr_q   <= miss_addr;
                        victim_addr_q <= victim_addr;
                        way_q         <= victim_way;
                    end
                end
                WB_REQ: if (mem.mem_req_ready) count_q <= '0;
                WB_RD:  rd_pending_q <= 1'b1;
                WB_DATA: begin
                    if (rd_pending_q) wdata_q <= wb_rd_data;
                    if (mem.mem_wdata_ready && count_q != LAST_WORD) count_q <= count_q + 1'b1;
                end
                RD_REQ: if (mem.mem_req_ready) count_q <= '0;
                RD_DATA: begin
                    if (mem.mem_rdata_valid && !fill_done_q && !err_q) begin
                        fill_we_q   <= 1'b1;
                        fill_way_q  <= way_q;
                        fill_word_q <= count_q;
                        fill_data_q <= mem.mem_rdata;
                        if (count_q == LAST_WORD) begin
                            fill_done_q <= 1'b1;
                            err_q       <= !mem.mem_rdata_last;
                        end else begin
                            err_q   <= mem.mem_rdata_last;
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fill_we   = fill_we_q;
    assign fill_way  = fill_way_q;
    assign fill_word = fill_word_q;
    assign fill_data = fill_data_q;
    assign fill_done = fill_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// Scoreboard bench for cache_refill_engine: memory and way models driven from
// scenario tasks, negedge monitors pop expected commands, beats and fills.
module tb_cache_refill_engine;

    typedef struct packed {
        logic [1:0]  way;
        logic [2:0]  word;
        logic [31:0] data;
        logic        done;
    } fill_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_valid, miss_ready;
    logic [31:0] miss_addr, victim_addr;
    logic [1:0]  victim_way;
    logic        victim_dirty;
    logic        wb_rd_en;
    logic [1:0]  wb_rd_way;
    logic [2:0]  wb_rd_word;
    logic [31:0] wb_rd_data;
    logic        fill_we, fill_done, err;
    logic [1:0]  fill_way;
    logic [2:0]  fill_word;
    logic [31:0] fill_data;

    cache_refill_engine_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) mif ();

    cache_refill_engine dut (
        .clk          (clk),
        .reset        (reset),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_addr    (miss_addr),
        .victim_way   (victim_way),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .wb_rd_en     (wb_rd_en),
        .wb_rd_way    (wb_rd_way),
        .wb_rd_word   (wb_rd_word),
        .wb_rd_data   (wb_rd_data),
        .fill_we      (fill_we),
        .fill_way     (fill_way),
        .fill_word    (fill_word),
        .fill_data    (fill_data),
        .fill_done    (fill_done),
        .err          (err),
        .mem          (mif)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          err_seen = 0;
    int          wfirst = 0;
    int          wlast = 0;
    logic [1:0]  cur_way = '0;
    logic [32:0] exp_req[$];
    logic [31:0] exp_wdata[$];
    fill_exp_t   exp_fill[$];

    logic        req_pend = 1'b0, wd_pend = 1'b0;
    logic [32:0] p_req;
    logic [31:0] p_wdata;

    always @(posedge clk) cyc++;

    // Synchronous way RAM: victim word n reads back as 0xD0+n
    always @(posedge clk) if (wb_rd_en) wb_rd_data <= 32'hD0 + 32'(wb_rd_word);

    always @(negedge clk) begin
        fill_exp_t   fe;
        logic [32:0] er;
        logic [31:0] ew;
        if (reset) begin
            req_pend = 1'b0;
            wd_pend  = 1'b0;
        end else begin
            total++;
            if (mif.mem_req_valid && mif.mem_wdata_valid) begin
                bad++;
                $display("[TB] FAIL phase_overlap got req_valid=1 wdata_valid=1 want one of them 0");
            end
            if (req_pend) begin
                total++;
                if ({mif.mem_req_valid, mif.mem_req_write, mif.mem_req_addr} !== {1'b1, p_req}) begin
                    bad++;
                    $display("[TB] FAIL req_stable got v=%0b cmd=%h want v=1 cmd=%h",
                             mif.mem_req_valid, {mif.mem_req_write, mif.mem_req_addr}, p_req);
                end
            end
            if (mif.mem_req_valid && mif.mem_req_ready) begin
                total++;
                if (exp_req.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL req_unexpected got cmd=%h want none",
                             {mif.mem_req_write, mif.mem_req_addr});
                end else begin
                    er = exp_req.pop_front();
                    if ({mif.mem_req_write, mif.mem_req_addr} !== er) begin
                        bad++;
                        $display("[TB] FAIL req_cmd got %h want %h",
                                 {mif.mem_req_write, mif.mem_req_addr}, er);
                    end
                end
            end
            req_pend = mif.mem_req_valid && !mif.mem_req_ready;
            p_req    = {mif.mem_req_write, mif.mem_req_addr};

            if (wd_pend) begin
                total++;
                if ({mif.mem_wdata_valid, mif.mem_wdata} !== {1'b1, p_wdata}) begin
                    bad++;
                    $display("[TB] FAIL wdata_stable got v=%0b d=%h want v=1 d=%h",
                             mif.mem_wdata_valid, mif.mem_wdata, p_wdata);
                end
            end
            if (mif.mem_wdata_valid && mif.mem_wdata_ready) begin
                total++;
                if (exp_wdata.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL wdata_unexpected got %h want none", mif.mem_wdata);
                end else begin
                    ew = exp_wdata.pop_front();
                    if (ew == 32'hD0) wfirst = cyc;
                    if (ew == 32'hD7) wlast = cyc;
                    if (mif.mem_wdata !== ew) begin
                        bad++;
                        $display("[TB] FAIL wdata got %h want %h", mif.mem_wdata, ew);
                    end
                end
            end
            wd_pend = mif.mem_wdata_valid && !mif.mem_wdata_ready;
            p_wdata = mif.mem_wdata;

            if (wb_rd_en) begin
                total++;
                if (wb_rd_way !== cur_way) begin
                    bad++;
                    $display("[TB] FAIL wb_rd_way got %0d want %0d", wb_rd_way, cur_way);
                end
            end
            if (fill_we) begin
                total++;
                if (exp_fill.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL fill_unexpected got word=%0d data=%h want none", fill_word, fill_data);
                end else begin
                    fe = exp_fill.pop_front();
                    if ({fill_way, fill_word, fill_data, fill_done} !== fe) begin
                        bad++;
                        $display("[TB] FAIL fill got way=%0d word=%0d data=%h done=%0b want way=%0d word=%0d data=%h done=%0b",
                                 fill_way, fill_word, fill_data, fill_done, fe.way, fe.word, fe.data, fe.done);
                    end
                end
            end else if (fill_done) begin
                total++;
                bad++;
                $display("[TB] FAIL fill_done_alone got fill_done=1 fill_we=0 want fill_done=0");
            end
            if (err) err_seen++;
        end
    end

    task automatic issue_miss(input logic [31:0] addr, input logic [1:0] way,
                              input logic dirty, input logic [31:0] vaddr);
        for (int i = 0; i < 100 && miss_ready !== 1'b1; i++) begin @(posedge clk); #1; end
        if (miss_ready !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL miss_ready_timeout got 0 want 1");
        end
        cur_way = way;
        if (dirty) begin
            exp_req.push_back({1'b1, vaddr & 32'hFFFF_FFE0});
            for (int k = 0; k < 8; k++) exp_wdata.push_back(32'hD0 + 32'(k));
        end
        exp_req.push_back({1'b0, addr & 32'hFFFF_FFE0});
        miss_valid = 1'b1; miss_addr = addr; victim_way = way;
        victim_dirty = dirty; victim_addr = vaddr;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        total++;
        if ({mif.mem_req_valid, miss_ready} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL req_latency got valid=%0b miss_ready=%0b want valid=1 miss_ready=0",
                     mif.mem_req_valid, miss_ready);
        end
    endtask

    task automatic serve_req(input int delay);
        for (int i = 0; i < 200 && mif.mem_req_valid !== 1'b1; i++) begin @(posedge clk); #1; end
        if (mif.mem_req_valid !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL req_timeout got valid=0 want 1");
        end
        repeat (delay) begin @(posedge clk); #1; end
        mif.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mif.mem_req_ready = 1'b0;
    endtask

    task automatic serve_wb(input int nbeats, input bit toggle);
        for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i < 50 && mif.mem_wdata_valid !== 1'b1; i++) begin @(posedge clk); #1; end
            if (mif.mem_wdata_valid !== 1'b1) begin
                total++; bad++;
                $display("[TB] FAIL wdata_timeout beat=%0d got valid=0 want 1", b);
            end
            if (toggle && (b % 2 == 1)) begin @(posedge clk); #1; end
            mif.mem_wdata_ready = 1'b1;
            @(posedge clk); #1;
            mif.mem_wdata_ready = 1'b0;
        end
    endtask

    task automatic send_beats(input logic [1:0] way, input int nbeats, input int last_at,
                              input logic [31:0] base, input bit gap);
        logic exp_done, exp_err;
        exp_done = (nbeats == 8);
        exp_err  = (last_at != 7);
        for (int i = 0; i < nbeats; i++) begin
            if (gap && (i % 2 == 1)) begin
                mif.mem_rdata_valid = 1'b0;
                @(posedge clk); #1;
            end
            mif.mem_rdata_valid = 1'b1;
            mif.mem_rdata       = base + 32'(i);
            mif.mem_rdata_last  = (i == last_at);
            exp_fill.push_back('{way: way, word: 3'(i), data: base + 32'(i), done: (i == 7)});
            @(posedge clk); #1;
        end
        mif.mem_rdata_valid = 1'b0;
        mif.mem_rdata_last  = 1'b0;
        total++;
        if ({fill_we, fill_done, err, miss_ready} !== {1'b1, exp_done, exp_err, 1'b0}) begin
            bad++;
            $display("[TB] FAIL close_beat got we=%0b done=%0b err=%0b ready=%0b want we=1 done=%0b err=%0b ready=0",
                     fill_we, fill_done, err, miss_ready, exp_done, exp_err);
        end
        @(posedge clk); #1;
        total++;
        if ({fill_we, fill_done, err, miss_ready} !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL after_close got we=%0b done=%0b err=%0b ready=%0b want 0001",
                     fill_we, fill_done, err, miss_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({miss_ready, mif.mem_req_valid, mif.mem_wdata_valid, wb_rd_en, fill_we, fill_done, err} !== 7'b1000000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got %b want 1000000",
                     {miss_ready, mif.mem_req_valid, mif.mem_wdata_valid, wb_rd_en, fill_we, fill_done, err});
        end
        total++;
        if ({mif.mem_req_addr, mif.mem_wdata, fill_data, fill_word, fill_way} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_data got addr=%h wdata=%h fdata=%h want all 0",
                     mif.mem_req_addr, mif.mem_wdata, fill_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clean_miss();
        issue_miss(32'h0000_1234, 2'd2, 1'b0, 32'h0);
        serve_req(0);
        send_beats(2'd2, 8, 7, 32'hA0, 1'b0);
    endtask

    task automatic test_dirty_miss();
        issue_miss(32'h0000_5678, 2'd1, 1'b1, 32'h0000_8040);
        serve_req(0);
        serve_wb(8, 1'b0);
        total++;
        if (mif.mem_req_valid !== 1'b1 || mif.mem_req_write !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fill_req_after_wb got valid=%0b write=%0b want valid=1 write=0",
                     mif.mem_req_valid, mif.mem_req_write);
        end
        total++;
        if (wlast - wfirst !== 14) begin
            bad++;
            $display("[TB] FAIL wb_throughput got %0d cycles want 14", wlast - wfirst);
        end
        serve_req(0);
        send_beats(2'd1, 8, 7, 32'h5500, 1'b0);
    endtask

    task automatic test_backpressure();
        issue_miss(32'h0002_00E4, 2'd0, 1'b1, 32'h0001_007F);
        serve_req(5);
        serve_wb(8, 1'b1);
        serve_req(5);
        send_beats(2'd0, 8, 7, 32'hBEEF_0000, 1'b1);
    endtask

    task automatic test_early_last();
        issue_miss(32'h0000_3000, 2'd1, 1'b0, 32'h0);
        serve_req(0);
        send_beats(2'd1, 5, 4, 32'hC0, 1'b0);
    endtask

    task automatic test_missing_last();
        issue_miss(32'h0000_4010, 2'd3, 1'b0, 32'h0);
        serve_req(1);
        send_beats(2'd3, 8, -1, 32'hE0, 1'b0);
    endtask

    task automatic test_reset_mid_wb();
        issue_miss(32'h0000_9000, 2'd3, 1'b1, 32'h0000_C0A0);
        serve_req(0);
        serve_wb(3, 1'b0);
        for (int i = 0; i < 10 && mif.mem_wdata_valid !== 1'b1; i++) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({miss_ready, mif.mem_req_valid, mif.mem_wdata_valid, wb_rd_en, fill_we, fill_done, err} !== 7'b1000000) begin
            bad++;
            $display("[TB] FAIL midreset_ctrl got %b want 1000000",
                     {miss_ready, mif.mem_req_valid, mif.mem_wdata_valid, wb_rd_en, fill_we, fill_done, err});
        end
        total++;
        if ({mif.mem_req_addr, mif.mem_wdata, fill_data} !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_data got addr=%h wdata=%h fdata=%h want all 0",
                     mif.mem_req_addr, mif.mem_wdata, fill_data);
        end
        reset = 1'b0;
        exp_wdata.delete();
        exp_req.delete();
        issue_miss(32'h0000_0FFC, 2'd0, 1'b0, 32'h0);
        serve_req(0);
        send_beats(2'd0, 8, 7, 32'hB0, 1'b0);
    endtask

    task automatic test_stray_rdata();
        mif.mem_rdata_valid = 1'b1;
        mif.mem_rdata       = 32'hDEAD_BEEF;
        mif.mem_rdata_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({fill_we, err, miss_ready, mif.mem_req_valid} !== 4'b0010) begin
                bad++;
                $display("[TB] FAIL stray_rdata got we=%0b err=%0b ready=%0b req=%0b want 0010",
                         fill_we, err, miss_ready, mif.mem_req_valid);
            end
        end
        mif.mem_rdata_valid = 1'b0;
        mif.mem_rdata_last  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_drain();
        total++;
        if (exp_req.size() + exp_wdata.size() + exp_fill.size() !== 0) begin
            bad++;
            $display("[TB] FAIL drain got req=%0d wdata=%0d fill=%0d want 0 0 0",
                     exp_req.size(), exp_wdata.size(), exp_fill.size());
        end
        total++;
        if (err_seen !== 2) begin
            bad++;
            $display("[TB] FAIL err_count got %0d want 2", err_seen);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        miss_valid = 1'b0; miss_addr = '0; victim_way = '0;
        victim_dirty = 1'b0; victim_addr = '0;
        mif.mem_req_ready = 1'b0; mif.mem_wdata_ready = 1'b0;
        mif.mem_rdata_valid = 1'b0; mif.mem_rdata = '0; mif.mem_rdata_last = 1'b0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid_wb();
        test_stray_rdata();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
